fifo_uart_tx: RTL

- Read-side consumer of the async byte FIFO, clocked in the read domain.
- Pulls one byte at a time through the FIFO read port (rd_en / buf_out / buf_empty).
- Serializes each byte as an asynchronous serial frame on tx: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
- Reports frame completion and a running count of bytes sent.

---
 rtl/fifo_uart_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// Read-domain consumer of the async byte FIFO: pops one byte at a time and
// serializes it as start, 8 data bits LSB first, optional parity, 1-2 stop bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic        rd_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        buf_empty,
  input  logic [7:0]  buf_out,
  output logic        rd_en,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] byte_count
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, REQ, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_next;
  logic [BW-1:0]   baud;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            parity_bit;
  logic            baud_last;

  assign baud_last = (baud == BAUD_LAST);

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable && !buf_empty) state_next = REQ;
      REQ:     state_next = LOAD;
      LOAD:    state_next = START;
      START:   if (baud_last) state_next = DATA;
      DATA:    if (baud_last && bit_cnt == 3'd7)
                 state_next = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (baud_last) state_next = STOP;
      STOP:    if (baud_last && bit_cnt == STOP_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // tx is decoded from registered state only, so it never glitches on inputs.
  always_comb begin
    tx = 1'b1;
    unique case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      PARITY:  tx = parity_bit;
      default: tx = 1'b1;
    endcase
  end

  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && baud_last && (bit_cnt == STOP_LAST);

  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state      <= IDLE;
      rd_en      <= 1'b0;
      baud       <= '0;
      bit_cnt    <= 3'd0;
      shift      <= 8'd0;
      parity_bit <= 1'b0;
      byte_count <= 16'd0;
    end else begin
      state <= state_next;
      rd_en <= (state_next == REQ);

      if (state inside {START, DATA, PARITY, STOP})
        baud <= baud_last ? '0 : baud + 1'b1;
      else
        baud <= '0;

      if (state == LOAD) begin
        shift      <= buf_out;
        parity_bit <= (^buf_out) ^ (PARITY_ODD != 0);
      end

      // bit_cnt wraps 7 -> 0 leaving DATA, so STOP always starts counting at 0.
      if (state == DATA && baud_last) begin
        shift   <= shift >> 1;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == STOP && baud_last)
        bit_cnt <= frame_done ? 3'd0 : bit_cnt + 3'd1;

      if (frame_done)
        byte_count <= byte_count + 16'd1;
    end
  end

endmodule
